mmss_timer_ctrl: RTL

//  Parametrised mm:ss timer core: next generation of the lab countdown timer. One clock domain;

---
 rtl/mmss_timer_ctrl_pkg.sv | 31 +++
 rtl/bcd_mmss_stepper.sv | 40 ++++
 rtl/mmss_timer_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mmss_timer_ctrl_pkg.sv
// Shared types and helpers for the mm:ss timer: state codes, BCD widths and
// two-digit BCD increment/decrement helpers.
package mmss_timer_ctrl_pkg;

    localparam int BCD_W  = 4;
    localparam int MMSS_W = 16;

    typedef enum logic [2:0] {
        TIMER_READY   = 3'd0,
        TIMER_RUNNING = 3'd1,
        TIMER_PAUSED  = 3'd2,
        TIMER_DONE    = 3'd3,
        TIMER_SETTING = 3'd4
    } timer_state_e;

    function automatic logic [2*BCD_W-1:0] to_bcd8(input int unsigned v);
        return {BCD_W'((v / 10) % 10), BCD_W'(v % 10)};
    endfunction

    // Callers guarantee the value is below 99 (resp. above 00).
    function automatic logic [7:0] bcd8_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd8_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mmss_stepper.sv
// Combinational one-second step of a BCD {mm,ss} word, up or down, with
// seconds wrap/borrow and minutes wrapping at MIN_MAX.
module bcd_mmss_stepper
    import mmss_timer_ctrl_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic [MMSS_W-1:0] cur,
    input  logic              up,
    output logic [MMSS_W-1:0] nxt
);

    localparam logic [7:0] MM_MAX = to_bcd8(MIN_MAX);

    logic [7:0] mm;
    logic [7:0] ss;

    assign mm = cur[15:8];
    assign ss = cur[7:0];

    always_comb begin
        nxt = cur;
        if (up) begin
            if (ss == 8'h59) begin
                nxt[7:0]  = 8'h00;
                nxt[15:8] = (mm == MM_MAX) ? 8'h00 : bcd8_inc(mm);
            end else begin
                nxt[7:0] = bcd8_inc(ss);
            end
        end else begin
            if (ss == 8'h00) begin
                nxt[7:0]  = 8'h59;
                nxt[15:8] = (mm == 8'h00) ? MM_MAX : bcd8_dec(mm);
            end else begin
                nxt[7:0] = bcd8_dec(ss);
            end
        end
    end

endmodule

// File: rtl/mmss_timer_ctrl.sv
// mm:ss up/down timer core with 1 s prescaler, setting mode and DONE state.
// Optional DONE_BLINK_EN: blank blinks at ~1 Hz while in DONE.
module mmss_timer_ctrl
    import mmss_timer_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 100_000_000,
    parameter int MIN_MAX   = 59,
    parameter int RESET_MIN = 1,
    parameter int RESET_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_switch,
    input  logic       pause,
    input  logic       restart,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       dir,
    output logic [7:0] q_min,
    output logic [7:0] q_sec,
    output logic [2:0] state,
    output logic       tick,
    output logic       done,
    output logic       blank
);

    localparam int              PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]      MM_MAX     = to_bcd8(MIN_MAX);
    localparam logic [MMSS_W-1:0] RST_MMSS = {to_bcd8(RESET_MIN), to_bcd8(RESET_SEC)};

    timer_state_e      st, st_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [MMSS_W-1:0] cnt, cnt_nxt, tgt, tgt_nxt, step_val, reload;
    logic              dir_q, dir_nxt, step_en, at_end;

    assign state  = st;
    assign reload = dir ? '0 : tgt;

    bcd_mmss_stepper #(.MIN_MAX(MIN_MAX)) u_step (
        .cur (cnt),
        .up  (dir_q),
        .nxt (step_val)
    );

    assign at_end = dir_q ? (step_val == tgt) : (step_val == '0);

    always_comb begin
        st_nxt  = st;
        step_en = 1'b0;
        if (mode_switch) begin
            st_nxt = TIMER_SETTING;
        end else begin
            unique case (st)
                TIMER_SETTING: st_nxt = TIMER_READY;
                TIMER_READY: begin
                    // target 00:00 is already the end value in either direction
                    if (restart)    st_nxt = TIMER_READY;
                    else if (pause) st_nxt = (tgt == '0) ? TIMER_DONE : TIMER_RUNNING;
                end
                TIMER_RUNNING: begin
                    if (restart)      st_nxt = TIMER_READY;
                    else if (pause)   st_nxt = TIMER_PAUSED;
                    else if (presc == PRESC_LAST) begin
                        step_en = 1'b1;
                        if (at_end) st_nxt = TIMER_DONE;
                    end
                end
                TIMER_PAUSED: begin
                    if (restart)    st_nxt = TIMER_READY;
                    else if (pause) st_nxt = TIMER_RUNNING;
                end
                TIMER_DONE: if (restart) st_nxt = TIMER_READY;
                default: st_nxt = TIMER_READY;
            endcase
        end
    end

    always_comb begin
        // phase survives a pause/resume; anything else outside RUNNING restarts it
        if (st == TIMER_RUNNING && (st_nxt == TIMER_RUNNING || st_nxt == TIMER_DONE))
            presc_nxt = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        else if (st_nxt == TIMER_RUNNING || st_nxt == TIMER_PAUSED)
            presc_nxt = presc;
        else
            presc_nxt = '0;

        if (step_en)
            cnt_nxt = step_val;
        else if (st == TIMER_READY || st_nxt == TIMER_READY || st_nxt == TIMER_SETTING)
            cnt_nxt = reload;
        else
            cnt_nxt = cnt;

        dir_nxt = (st == TIMER_READY && (st_nxt == TIMER_RUNNING || st_nxt == TIMER_DONE))
                  ? dir : dir_q;

        tgt_nxt = tgt;
        if (st == TIMER_SETTING && mode_switch) begin
            if (inc_min) tgt_nxt[15:8] = (tgt[15:8] == MM_MAX) ? 8'h00 : bcd8_inc(tgt[15:8]);
            if (inc_sec) tgt_nxt[7:0]  = (tgt[7:0] == 8'h59)   ? 8'h00 : bcd8_inc(tgt[7:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= TIMER_READY;
            presc <= '0;
            tgt   <= RST_MMSS;
            cnt   <= RST_MMSS;
            dir_q <= 1'b0;
            q_min <= RST_MMSS[15:8];
            q_sec <= RST_MMSS[7:0];
            tick  <= 1'b0;
            done  <= 1'b0;
        end else begin
            st    <= st_nxt;
            presc <= presc_nxt;
            tgt   <= tgt_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
            q_min <= (st_nxt == TIMER_SETTING) ? tgt_nxt[15:8] : cnt_nxt[15:8];
            q_sec <= (st_nxt == TIMER_SETTING) ? tgt_nxt[7:0]  : cnt_nxt[7:0];
            tick  <= step_en;
            done  <= (st_nxt == TIMER_DONE);
        end
    end

`ifdef DONE_BLINK_EN
    localparam int            HALF       = CLK_DIV / 2;
    localparam int            BW         = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

    logic [BW-1:0] bcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt  <= '0;
            blank <= 1'b0;
        end else if (st_nxt != TIMER_DONE || st != TIMER_DONE) begin
            bcnt  <= '0;
            blank <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt  <= '0;
            blank <= ~blank;
        end else begin
            bcnt  <= bcnt + 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule
